mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 63 ++++++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage_load_ext.sv | 22 ++
 rtl/mem_stage.sv | 108 ++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, memory-op encodings, state encoding and op-decode helpers
// for the MEM pipeline stage.
package mem_stage_pkg;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned MEM_OP_W   = 4;
  localparam int unsigned SIZE_W     = 2;

  localparam logic [REG_ADDR_W-1:0] REG_ADDR_NOP = '0;
  localparam logic [REG_W-1:0]      ZERO_WORD    = '0;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Memory transaction captured when the stage leaves IDLE.
  typedef struct packed {
    logic [MEM_OP_W-1:0]   op;
    logic [REG_W-1:0]      addr;
    logic [REG_W-1:0]      wdata;
    logic [REG_ADDR_W-1:0] dest;
    logic                  en;
  } mem_txn_t;

  function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic mem_size_e op_size(input logic [MEM_OP_W-1:0] op);
    mem_size_e s;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: s = SIZE_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: s = SIZE_HALF;
      default:                 s = SIZE_WORD;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// Request/response bus between the MEM stage (master) and the memory controller.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_we;
  logic [REG_W-1:0]  mem_req_addr;
  logic [REG_W-1:0]  mem_req_wdata;
  logic [SIZE_W-1:0] mem_req_size;
  logic              mem_req_ready;
  logic              mem_done;
  logic [REG_W-1:0]  mem_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_size,
    input  mem_req_ready, mem_done, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_size,
    output mem_req_ready, mem_done, mem_rdata
  );
endinterface

// File: rtl/mem_stage_load_ext.sv
// Combinational load-data extension: sign-extends LB/LH, zero-extends LBU/LHU,
// passes everything else through unchanged.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [MEM_OP_W-1:0] op_i,
  input  logic [REG_W-1:0]    raw_i,
  output logic [REG_W-1:0]    ext_data_o
);

  always_comb begin
    ext_data_o = raw_i;
    case (op_i)
      MEM_LB:  ext_data_o = {{(REG_W-8){raw_i[7]}},   raw_i[7:0]};
      MEM_LH:  ext_data_o = {{(REG_W-16){raw_i[15]}}, raw_i[15:0]};
      MEM_LBU: ext_data_o = {{(REG_W-8){1'b0}},       raw_i[7:0]};
      MEM_LHU: ext_data_o = {{(REG_W-16){1'b0}},      raw_i[15:0]};
      default: ext_data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results straight through, and runs loads/stores
// as a single outstanding request to the memory controller while stalling the pipe.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  ex_reg_write_en,
  input  logic [REG_ADDR_W-1:0] ex_reg_write_dest,
  input  logic [REG_W-1:0]      ex_reg_write_data,
  input  logic [MEM_OP_W-1:0]   ex_mem_op,
  input  logic [REG_W-1:0]      ex_mem_wdata,
  mem_stage_if.master           bus,
  output logic                  mem_reg_write_en,
  output logic [REG_ADDR_W-1:0] mem_reg_write_dest,
  output logic [REG_W-1:0]      mem_reg_write_data,
  output logic                  stall_req
);

  mem_state_e       state_q, state_d;
  mem_txn_t         cap_q, cap_d;
  logic [REG_W-1:0] result_q, result_d;
  logic [REG_W-1:0] ext_data;
  logic             ex_is_mem;

  assign ex_is_mem = is_load(ex_mem_op) || is_store(ex_mem_op);

  mem_load_ext u_load_ext (
    .op_i       (cap_q.op),
    .raw_i      (bus.mem_rdata),
    .ext_data_o (ext_data)
  );

  // State, captured transaction and load result; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cap_q    <= '0;
      result_q <= ZERO_WORD;
    end else if (rdy) begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    cap_d              = cap_q;
    result_d           = result_q;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_we     = is_store(cap_q.op);
    bus.mem_req_addr   = cap_q.addr;
    bus.mem_req_wdata  = cap_q.wdata;
    bus.mem_req_size   = op_size(cap_q.op);
    mem_reg_write_en   = 1'b0;
    mem_reg_write_dest = REG_ADDR_NOP;
    mem_reg_write_data = ZERO_WORD;
    stall_req          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_reg_write_dest = ex_reg_write_dest;
        mem_reg_write_data = ex_reg_write_data;
        mem_reg_write_en   = ex_reg_write_en && !ex_is_mem;
        stall_req          = ex_is_mem;
        if (ex_is_mem) begin
          state_d     = ST_REQ;
          cap_d.op    = ex_mem_op;
          cap_d.addr  = ex_reg_write_data;
          cap_d.wdata = ex_mem_wdata;
          cap_d.dest  = ex_reg_write_dest;
          cap_d.en    = ex_reg_write_en;
        end
      end
      ST_REQ: begin
        bus.mem_req_valid = 1'b1;
        stall_req         = 1'b1;
        if (bus.mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        stall_req = 1'b1;
        if (bus.mem_done) begin
          state_d  = ST_DONE;
          result_d = ext_data;
        end
      end
      ST_DONE: begin
        mem_reg_write_en   = cap_q.en && is_load(cap_q.op);
        mem_reg_write_dest = cap_q.dest;
        mem_reg_write_data = result_q;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset cycle presents a clean bubble even with a live EX/MEM latch upstream.
    if (rst) begin
      bus.mem_req_valid  = 1'b0;
      mem_reg_write_en   = 1'b0;
      mem_reg_write_dest = REG_ADDR_NOP;
      mem_reg_write_data = ZERO_WORD;
      stall_req          = 1'b0;
    end
  end

endmodule
